// File: rtl/cube_solver.sv
// Counts face-connected cell subsets of a 2x2x3 grid by flood-filling every nonempty mask.
// Define CUBE_SOLVER_SMALL_GRID_EN to shrink the grid to 2x2x2 (masks 1..255).
module cube_solver (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [11:0] total_found,
  output logic        solver_done
);

`ifdef CUBE_SOLVER_SMALL_GRID_EN
  localparam logic [11:0] CellMask = 12'h0FF;
`else
  localparam logic [11:0] CellMask = 12'hFFF;
`endif
  localparam logic [11:0] LastMask = CellMask;
  localparam logic [11:0] SatValue = 12'hFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    GROW  = 3'd2,
    CHECK = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Cell index is x + 2y + 4z: x toggles bit 0, y toggles bit 1, z steps by 4.
  function automatic logic [11:0] neighbours(input logic [11:0] r);
    logic [11:0] n;
    n = ((r & 12'h555) << 1) | ((r & 12'hAAA) >> 1)
      | ((r & 12'h333) << 2) | ((r & 12'hCCC) >> 2)
      | (r << 4) | (r >> 4);
    return n & CellMask;
  endfunction

  state_e      state_q, state_d;
  logic [11:0] mask_q, mask_d;
  logic [11:0] reached_q, reached_d;
  logic [11:0] total_q, total_d;
  logic        done_q, done_d;
  logic [11:0] grown_s;

  assign grown_s = reached_q | (neighbours(reached_q) & mask_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q    <= 12'h000;
      reached_q <= 12'h000;
      total_q   <= 12'h000;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      reached_q <= reached_d;
      total_q   <= total_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    reached_d = reached_q;
    total_d   = total_q;
    done_d    = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (run) begin
          total_d = 12'h000;
          mask_d  = 12'h001;
          done_d  = 1'b0;
          state_d = INIT;
        end else begin
          state_d = state_q;
        end
      end
      INIT: begin
        // Seed the fill with the lowest set cell of the mask.
        reached_d = mask_q & (~mask_q + 12'h001);
        state_d   = GROW;
      end
      GROW: begin
        if (grown_s == reached_q) begin
          state_d = CHECK;
        end else begin
          reached_d = grown_s;
        end
      end
      CHECK: begin
        if ((reached_q == mask_q) && (total_q != SatValue)) begin
          total_d = total_q + 12'h001;
        end else begin
          total_d = total_q;
        end
        state_d = NEXT;
      end
      NEXT: begin
        if (mask_q == LastMask) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          mask_d  = (mask_q + 12'h001) & CellMask;
          state_d = INIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign total_found = total_q;
  assign solver_done = done_q;

endmodule

// File: tb/tb_cube_solver.sv
// Self-checking bench for cube_solver: coordinate-based flood-fill model plus directed scenarios.
module tb_cube_solver;
`ifdef CUBE_SOLVER_SMALL_GRID_EN
  localparam int NC = 8;
`else
  localparam int NC = 12;
`endif
  localparam int LAST = (1 << NC) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [11:0] total_found;
  logic        solver_done;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;
  int ref_cnt;
  int first_cnt;

  int m_total  = 0;
  int m_done   = 0;
  bit m_active = 1'b0;
  int m_mask, m_idx, m_len;
  bit m_valid;

  cube_solver dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .total_found(total_found),
    .solver_done(solver_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit adjacent(input int a, input int b);
    int dx, dy, dz;
    dx = (a % 2) - (b % 2);
    dy = ((a / 2) % 2) - ((b / 2) % 2);
    dz = (a / 4) - (b / 4);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    if (dz < 0) dz = -dz;
    return (dx + dy + dz) == 1;
  endfunction

  // Layered flood fill from the lowest cell; k = number of layers that added cells.
  function automatic void bfs(input int mask, input int n, output bit valid, output int k);
    int seed, reached, nxt;
    seed = 0;
    while (seed < n && ((mask >> seed) & 1) == 0) seed++;
    reached = 1 << seed;
    k = 0;
    for (int it = 0; it < n; it++) begin
      nxt = reached;
      for (int a = 0; a < n; a++)
        if (((mask >> a) & 1) == 1 && ((reached >> a) & 1) == 0)
          for (int b = 0; b < n; b++)
            if (((reached >> b) & 1) == 1 && adjacent(a, b)) nxt = nxt | (1 << a);
      if (nxt == reached) break;
      reached = nxt;
      k++;
    end
    valid = (reached == mask);
  endfunction

  function automatic int count_valid(input int lo, input int hi, input int n);
    int cnt, k;
    bit v;
    cnt = 0;
    for (int m = lo; m <= hi; m++) begin
      bfs(m, n, v, k);
      if (v) cnt++;
    end
    return cnt;
  endfunction

  task automatic load_mask();
    int k;
    bfs(m_mask, NC, m_valid, k);
    m_len = 4 + k;
  endtask

  // Cycle model: each mask takes INIT + (k+1) GROW + CHECK + NEXT cycles.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_active = 1'b0; m_total = 0; m_done = 0;
      end else if (!m_active) begin
        if (run) begin
          m_total = 0; m_done = 0; m_active = 1'b1;
          m_mask = 1; m_idx = 0; load_mask();
        end
      end else begin
        if (m_idx == m_len - 2 && m_valid && m_total < 4095) m_total++;
        if (m_idx == m_len - 1) begin
          if (m_mask == LAST) begin
            m_active = 1'b0; m_done = 1;
          end else begin
            m_mask++; m_idx = 0; load_mask();
          end
        end else begin
          m_idx++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("trace_total", int'(total_found), m_total);
        chk("trace_done", int'(solver_done), m_done);
      end
    end
  end

  task automatic pulse_run();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (solver_done !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (solver_done !== 1'b1) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int k;
    bit v;
    chk("model_small_167", count_valid(1, 255, 8), 167);
    chk("model_first3", count_valid(1, 3, 12), 3);
    bfs(3, 12, v, k);
    chk("model_0x003_valid", int'(v), 1);
    chk("model_0x003_k", k, 1);
    bfs(9, 12, v, k);
    chk("model_0x009_valid", int'(v), 0);
    bfs(255, 8, v, k);
    chk("model_cube_k", k, 3);
    ref_cnt = count_valid(1, LAST, NC);

    rst = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    chk("reset_total", int'(total_found), 0);
    chk("reset_done", int'(solver_done), 0);
    repeat (100) @(negedge clk);
    chk("idle_total", int'(total_found), 0);
    chk("idle_done", int'(solver_done), 0);

    pulse_run();
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_total", int'(total_found), 0);
    chk("abort_done", int'(solver_done), 0);
    repeat (20) @(negedge clk);
    chk("abort_still_idle", int'(solver_done), 0);

    pulse_run();
    repeat (12) @(negedge clk);
    chk("after_0x003", int'(total_found), 3);
    repeat (7) @(negedge clk);
    pulse_run();
    wait_done(40000);
    chk("final_vs_ref", int'(total_found), ref_cnt);
`ifdef CUBE_SOLVER_SMALL_GRID_EN
    chk("final_167", int'(total_found), 167);
`endif
    first_cnt = int'(total_found);
    repeat (50) @(negedge clk);
    chk("hold_total", int'(total_found), first_cnt);
    chk("hold_done", int'(solver_done), 1);

    pulse_run();
    chk("restart_done_drop", int'(solver_done), 0);
    chk("restart_total_clear", int'(total_found), 0);
    wait_done(40000);
    chk("restart_final", int'(total_found), first_cnt);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cube_solver.md
CUBE_SOLVER -- requirements
Module: cube_solver

Interface
REQ-001 The block SHALL have no parameters; the grid size is selected only by the macro in Configuration.
REQ-002 clk  input  1  single clock; all logic is on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 run  input  1  start request, sampled each cycle; a one-cycle pulse is sufficient.
REQ-005 total_found  output  12  number of connected cell subsets counted so far, unsigned.
REQ-006 solver_done  output  1  high when enumeration is complete; held until reset or restart.

Function
REQ-007 The grid SHALL be 2x2x3 cells (12 cells), x,y in {0,1}, z in {0,1,2}.
REQ-008 Each cell SHALL have bit index x + 2y + 4z in a 12-bit mask.
REQ-009 Neighbours SHALL be face-adjacent cells only (+-1 in exactly one axis, within bounds); there is no wrap-around.
REQ-010 The block SHALL enumerate every nonempty mask from 1 to 2^N-1 in ascending order, with N the cell count.
REQ-011 A mask SHALL count as valid iff its set cells form one face-connected component; the empty set is never counted.
REQ-012 States: IDLE, INIT, GROW, CHECK, NEXT, DONE.
REQ-013 IDLE: on run=1, clear total_found, set the mask to 1, and go to INIT.
REQ-014 INIT: reached = lowest set bit of mask, then go to GROW.
REQ-015 GROW, one step per cycle: next = reached | (neighbours(reached) & mask).
REQ-016 GROW: if next equals reached, go to CHECK; otherwise load reached with next and stay in GROW.
REQ-017 CHECK: if reached equals mask, increment total_found by 1, then go to NEXT.
REQ-018 NEXT: if mask = 2^N-1, go to DONE; otherwise increment mask and go to INIT.
REQ-019 DONE: solver_done=1; on run=1, restart exactly as from IDLE and drop solver_done in the same cycle.
REQ-020 run SHALL be ignored in INIT, GROW, CHECK and NEXT.
REQ-021 total_found SHALL saturate at 4095; it cannot be reached for either grid but is required for safety.
REQ-022 total_found SHALL update live, one count per valid mask, and SHALL be stable once solver_done rises.
REQ-023 Latency per mask: 1 INIT cycle, then k+1 GROW cycles (k = number of expansions, at most N-1), then 1 CHECK cycle, then 1 NEXT cycle.
REQ-024 Total run time SHALL be finite and deterministic for a given grid.

Reset
REQ-025 When rst=1 at a clock edge, the state SHALL become IDLE, and total_found, solver_done, the mask and reached SHALL be 0.
REQ-026 Reset SHALL take priority over run in the same cycle.
REQ-027 Reset mid-operation SHALL abort the enumeration with no completion flagged.

Configuration
REQ-028 Macro CUBE_SOLVER_SMALL_GRID_EN selects the grid size.
REQ-029 When CUBE_SOLVER_SMALL_GRID_EN is defined, the grid SHALL be 2x2x2 (N=8, masks 1..255, z in {0,1}).
REQ-030 When CUBE_SOLVER_SMALL_GRID_EN is defined, mask bits 11:8 SHALL be tied to 0.
REQ-031 When CUBE_SOLVER_SMALL_GRID_EN is undefined, the grid SHALL be 2x2x3 (N=12) as in REQ-007.
REQ-032 The interface SHALL be identical in both builds.

Verification
REQ-033 Hold rst=1 for 5 cycles -> total_found=0 and solver_done=0; both remain 0 with run=0 for 100 cycles.
REQ-034 Small build, 1-cycle run pulse -> solver_done rises and total_found=167.
- 167 = 8+12+24+38+48+28+8+1 by subset size.
- solver_done stays high for 50 further cycles with total_found unchanged.
REQ-035 Full build, 1-cycle run pulse -> total_found equals a software flood-fill reference count over masks 1..4095.
- Hand check: the first three masks (0x001, 0x002, 0x003) each add 1, so total_found=3 after mask 0x003.
- Mask 0x009 (cells 0 and 3, diagonal only) adds 0.
REQ-036 Pulse run again 20 cycles after the first run -> ignored; final count is unchanged (167 in the small build).
REQ-037 Assert rst mid-run -> next cycle total_found=0 and solver_done=0; a new run pulse completes with the correct count.
REQ-038 Pulse run in DONE -> solver_done drops the next cycle, total_found clears, and the run completes with an identical count.
